rom_dump_sequencer: RTL and testbench
=====================================

// Module: rom_dump_sequencer
// PURPOSE
// Automatic full-dump controller for the IP3601 (256x4) and IP3604 (512x8) PROMs. On a start pulse it
// sweeps every address of the selected chip: drive address, select the chip, wait access time, capture
// data, and hand each word downstream over a valid/ready stream (UART or host link). It replaces
// manual button stepping and owns the shared address and chip-select GPIO lines during a dump.
// PARAMETERS
// ADDRESS_WIDTH   9    address bus width; IP3604 uses all bits, IP3601 uses [7:0]
// DATA_WIDTH      8    data width; IP3601 data occupies [3:0]
// SELECT_WIDTH    4    chip-select bus width; IP3601 uses [1:0]
// SETUP_CYCLES    16   clocks from address change to select assertion (>=1)
// ACCESS_CYCLES   50   clocks select is held low before data is sampled (>=1)
// PORTS
// clk                 in   1              system clock
// reset               in   1              asynchronous, active-high reset
// start               in   1              one-cycle request to begin a dump; ignored while busy
// abort               in   1              terminate current dump; return to IDLE
// chip_type           in   1              0 = IP3601, 1 = IP3604; sampled only on accepted start
// chip_data_in        in   DATA_WIDTH     data bus from the PROM
// chip_address        out  ADDRESS_WIDTH  address driven to the PROM
// chip_select_n       out  SELECT_WIDTH   active-low chip selects
// out_data            out  8              captured word (IP3601: {4'b0, nibble})
// out_address         out  ADDRESS_WIDTH  address belonging to out_data
// out_valid           out  1              out_data/out_address valid
// out_ready           in   1              downstream accepts word when out_valid & out_ready
// busy                out  1              high in every state except IDLE
// done                out  1              one-cycle pulse after last word accepted
// BEHAVIOUR
// - Reset (async): state IDLE, chip_address=0, chip_select_n=all 1, out_data=0, out_address=0,
//   out_valid=0, busy=0, done=0, internal chip_type latch=0, counters=0. All outputs registered.
// - States: IDLE, SETUP, ACCESS, CAPTURE, EMIT, ADVANCE, FINISH.
// - IDLE: start=1 -> latch chip_type, chip_address=0, load wait counter, -> SETUP.
// - SETUP: selects all 1; after SETUP_CYCLES clocks -> ACCESS.
// - ACCESS: IP3604 chip_select_n=4'b0000; IP3601 chip_select_n[1:0]=2'b00, upper bits stay 1.
//   After ACCESS_CYCLES clocks -> CAPTURE.
// - CAPTURE: one cycle; register chip_data_in (IP3601 masks to [3:0], [7:4]=0), out_address=chip_address,
//   release selects (all 1), -> EMIT with out_valid=1 on entry.
// - EMIT: out_valid/out_data/out_address held stable until out_valid&out_ready; on handshake
//   out_valid=0 next cycle, -> ADVANCE. out_ready high constantly => exactly 1 cycle in EMIT.
// - ADVANCE: last address (IP3601 8'hFF, IP3604 9'h1FF) -> FINISH; else chip_address+1 -> SETUP.
//   Address never wraps; last address is compared, not detected by overflow.
// - FINISH: done=1 for exactly one cycle, busy=0 next cycle, -> IDLE. chip_address holds last value.
// - Per-word latency with out_ready=1: SETUP_CYCLES+ACCESS_CYCLES+3 clocks.
// - abort: highest priority in any non-IDLE state; next cycle IDLE, selects all 1, out_valid=0,
//   no done pulse. abort and start together in IDLE -> stay IDLE.
// - start while busy: ignored, no effect on chip_type latch. chip_type changes mid-dump: ignored.
// - Reset mid-dump: immediate return to reset values regardless of state or pending handshake.
// STRUCTURE
// - Shared package rom_reader_pkg: chip-type constants (CHIP_IP3601=0, CHIP_IP3604=1), per-chip
//   last-address constants, state encoding enum/localparams.
// - One sub-module: wait_counter (loadable down-counter with zero flag) used by SETUP and ACCESS.
// - FSM, address counter and output registers in this module; no other hierarchy.
// TESTING
// - IP3604 dump, SETUP=2, ACCESS=3, out_ready=1, PROM model data=addr[7:0]^8'hA5 -> 512 words,
//   out_address 0..511 in order, each word 8 clocks apart, single done pulse after word 511.
// - IP3601 dump, model nibble=addr[3:0] -> 256 words, out_data[7:4]=0, chip_select_n[3:2]=2'b11
//   throughout, done after address 255.
// - Backpressure: out_ready low 10 cycles at address 5 -> out_valid/out_data stable, address stays 5,
//   selects high; release -> address 6 proceeds.
// - abort asserted in ACCESS at address 100 -> next cycle IDLE, busy=0, selects all 1, no done.
// - start pulses during a dump and chip_type toggled mid-dump -> no restart, chip type unchanged.
// - Async reset asserted mid-EMIT between clock edges -> outputs at reset values immediately; new
//   start afterwards begins at address 0.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: chip-type codes, last addresses and FSM state encoding for the PROM dump sequencer
package rom_reader_pkg;
  localparam logic CHIP_IP3601 = 1'b0;
  localparam logic CHIP_IP3604 = 1'b1;
  localparam int unsigned LAST_ADDR_IP3601 = 32'h0FF;
  localparam int unsigned LAST_ADDR_IP3604 = 32'h1FF;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;
endpackage

// File: rtl/rom_dump_sequencer_wait_counter.sv
// wait_counter: loadable down-counter, zero flag high once the loaded count has elapsed
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - W'(1);
  end
  assign zero = count == '0;
endmodule

// File: rtl/rom_dump_sequencer.sv
// rom_dump_sequencer: sweeps every address of an IP3601/IP3604 PROM and streams each word out
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int SELECT_WIDTH  = 4,
  parameter int SETUP_CYCLES  = 16,
  parameter int ACCESS_CYCLES = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     chip_type,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic [SELECT_WIDTH-1:0]  chip_select_n,
  output logic [7:0]               out_data,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);
  localparam int CW = $clog2((SETUP_CYCLES > ACCESS_CYCLES ? SETUP_CYCLES : ACCESS_CYCLES) + 1);
  localparam logic [SELECT_WIDTH-1:0] SEL_IP3601 = {{(SELECT_WIDTH-2){1'b1}}, 2'b00};
  logic [2:0] state;
  logic chip_type_q;
  logic cnt_zero;
  logic cnt_load;
  logic [CW-1:0] cnt_value;
  logic [ADDRESS_WIDTH-1:0] last_addr;
  logic at_last;
  always_comb begin
    last_addr = chip_type_q ? ADDRESS_WIDTH'(LAST_ADDR_IP3604) : ADDRESS_WIDTH'(LAST_ADDR_IP3601);
    at_last = chip_address == last_addr;
    cnt_load = (state == S_IDLE && start) || (state == S_SETUP && cnt_zero) ||
               (state == S_ADVANCE && !at_last);
    cnt_value = state == S_SETUP ? CW'(ACCESS_CYCLES - 1) : CW'(SETUP_CYCLES - 1);
  end
  wait_counter #(.W(CW)) u_wait (
    .clk(clk),
    .reset(reset),
    .load(cnt_load),
    .load_value(cnt_value),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      chip_type_q <= CHIP_IP3601;
      chip_address <= '0;
      chip_select_n <= '1;
      out_data <= '0;
      out_address <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      chip_select_n <= '1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) begin
          chip_type_q <= chip_type;
          chip_address <= '0;
          busy <= 1'b1;
          state <= S_SETUP;
        end
        S_SETUP: if (cnt_zero) begin
          chip_select_n <= chip_type_q ? '0 : SEL_IP3601;
          state <= S_ACCESS;
        end
        S_ACCESS: if (cnt_zero) state <= S_CAPTURE;
        S_CAPTURE: begin
          out_data <= chip_type_q ? 8'(chip_data_in) : {4'b0, chip_data_in[3:0]};
          out_address <= chip_address;
          chip_select_n <= '1;
          out_valid <= 1'b1;
          state <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= S_ADVANCE;
        end
        // the last address is compared explicitly so the counter never wraps
        S_ADVANCE: if (at_last) begin
          done <= 1'b1;
          state <= S_FINISH;
        end else begin
          chip_address <= chip_address + ADDRESS_WIDTH'(1);
          state <= S_SETUP;
        end
        S_FINISH: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_dump_sequencer.sv
// tb_rom_dump_sequencer: table-driven full dumps plus abort, restart-ignore and async-reset sequences
module tb_rom_dump_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic chip_type = 1'b0;
  logic out_ready = 1'b1;
  logic model_3604 = 1'b1;
  logic [7:0] chip_data_in;
  logic [8:0] chip_address;
  logic [3:0] chip_select_n;
  logic [7:0] out_data;
  logic [8:0] out_address;
  logic out_valid;
  logic busy;
  logic done;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign chip_data_in = model_3604 ? (chip_address[7:0] ^ 8'hA5) : {4'hC, chip_address[3:0]};

  rom_dump_sequencer #(.SETUP_CYCLES(2), .ACCESS_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .chip_type(chip_type),
    .chip_data_in(chip_data_in),
    .chip_address(chip_address),
    .chip_select_n(chip_select_n),
    .out_data(out_data),
    .out_address(out_address),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic ct, input int a);
    logic [8:0] av;
    av = 9'(a);
    return ct ? (av[7:0] ^ 8'hA5) : {4'h0, av[3:0]};
  endfunction

  task automatic pulse_start(input logic ct);
    @(negedge clk);
    chip_type = ct;
    model_3604 = ct;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_addr_valid(input int a, input string name);
    int n;
    n = 0;
    while (!(out_valid && out_address == 9'(a)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait"}, 32'(n < 2000), 1);
  endtask

  task automatic run_dump(input logic ct, input int stall_at, input int words, input int last);
    int cyc, idx, dones, prev_rise, low_cycles, budget;
    logic prev_valid, done_after, sel_bad, upper_bad;
    logic [7:0] held;
    cyc = 0; idx = 0; dones = 0; prev_rise = 0; low_cycles = 0;
    prev_valid = 1'b0; done_after = 1'b0; sel_bad = 1'b0; upper_bad = 1'b0;
    budget = words * 8 + 100;
    out_ready = 1'b1;
    pulse_start(ct);
    while (cyc < budget && !(idx == words && !busy)) begin
      @(negedge clk);
      cyc++;
      if (chip_select_n != 4'hF) begin
        low_cycles++;
        if (chip_select_n != (ct ? 4'b0000 : 4'b1100)) sel_bad = 1'b1;
      end
      if (!ct && chip_select_n[3:2] != 2'b11) upper_bad = 1'b1;
      if (done) begin
        dones++;
        done_after = idx == words;
      end
      if (out_valid && !prev_valid) begin
        chk("word_addr", 32'(out_address), 32'(idx));
        chk("word_data", 32'(out_data), 32'(exp_data(ct, idx)));
        if (idx > 0 && idx != stall_at + 1) chk("word_period", 32'(cyc - prev_rise), 8);
        prev_rise = cyc;
        if (idx == stall_at) begin
          out_ready = 1'b0;
          held = out_data;
          repeat (10) begin
            @(negedge clk);
            cyc++;
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(held));
            chk("stall_addr", 32'(chip_address), 5);
            chk("stall_sel", 32'(chip_select_n), 32'hF);
          end
          out_ready = 1'b1;
        end
        idx++;
      end
      prev_valid = out_valid;
    end
    chk("dump_in_budget", 32'(cyc < budget), 1);
    chk("dump_words", 32'(idx), 32'(words));
    chk("done_count", 32'(dones), 1);
    chk("done_after_last", 32'(done_after), 1);
    chk("final_address", 32'(chip_address), 32'(last));
    chk("select_pattern", 32'(sel_bad), 0);
    chk("select_low_cycles", 32'(low_cycles), 32'(words * 4));
    chk("upper_selects_high", 32'(upper_bad), 0);
  endtask

  typedef struct {
    logic ct;
    int stall_at;
    int words;
    int last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dones;
    vecs[0] = '{ct: 1'b1, stall_at: -1, words: 512, last: 511};
    vecs[1] = '{ct: 1'b0, stall_at: -1, words: 256, last: 255};
    vecs[2] = '{ct: 1'b1, stall_at: 5, words: 512, last: 511};
    vecs[3] = '{ct: 1'b0, stall_at: 5, words: 256, last: 255};

    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(chip_address), 0);
    chk("rst_sel", 32'(chip_select_n), 32'hF);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy_done", 32'({busy, done}), 0);
    chk("rst_out", 32'({out_data, out_address}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_dump(vecs[i].ct, vecs[i].stall_at, vecs[i].words, vecs[i].last);

    // abort together with start in IDLE must not launch a dump
    @(negedge clk);
    start = 1'b1; abort = 1'b1; chip_type = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);

    // abort during ACCESS at address 100
    pulse_start(1'b1);
    begin
      int n;
      n = 0;
      while (!(chip_address == 9'd100 && chip_select_n == 4'b0000) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach", 32'(n < 2000), 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sel", 32'(chip_select_n), 32'hF);
    chk("abort_valid", 32'(out_valid), 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", 32'(dones), 0);

    // start pulses and chip_type toggling mid-dump are ignored
    pulse_start(1'b0);
    wait_addr_valid(10, "ign10");
    start = 1'b1;
    chip_type = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chip_type = ~chip_type;
    end
    wait_addr_valid(20, "ign20");
    chk("ign_data", 32'(out_data), 32'h04);
    chk("ign_busy", 32'(busy), 1);
    while (chip_select_n == 4'hF) @(negedge clk);
    chk("ign_sel", 32'(chip_select_n), 32'hC);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // async reset asserted between edges while a word waits in EMIT
    out_ready = 1'b0;
    pulse_start(1'b1);
    wait_addr_valid(0, "emit0");
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sel", 32'(chip_select_n), 32'hF);
    chk("arst_out", 32'({out_data, out_address, chip_address}), 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    pulse_start(1'b1);
    wait_addr_valid(0, "restart0");
    chk("restart_data", 32'(out_data), 32'hA5);
    wait_addr_valid(1, "restart1");
    chk("restart_data1", 32'(out_data), 32'hA4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
